// File: rtl/compuertas_pkg.sv
// Shared types and constants for the gate-unit sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package compuertas_pkg;

  // Sequencer states: idle, enable gate, hold inputs, sample, deliver table, end pulse
  typedef enum logic [2:0] {
    REPOSO   = 3'd0,
    ACTIVAR  = 3'd1,
    APLICAR  = 3'd2,
    MUESTREO = 3'd3,
    ENTREGA  = 3'd4,
    FIN      = 3'd5
  } estado_t;

  // A 3-input gate has 8 input combinations, indexed by a 3-bit counter
  localparam int NUM_COMB   = 8;
  localparam int ANCHO_COMB = 3;

  // Maximum settle count representable by the wait counter
  localparam int ANCHO_ESPERA = 4;

endpackage

// File: rtl/compuertas_espera.sv
// Settle counter: cleared by carga_i, counts while cuenta_i, flags when objetivo_i reached.
// Latency: listo_o is combinational from the count register (objetivo_i+1 counting cycles after clear).
// Backpressure: none; the counter saturates at the target until cleared again.
module compuertas_espera #(
  parameter int ANCHO = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             carga_i,
  input  logic             cuenta_i,
  input  logic [ANCHO-1:0] objetivo_i,
  output logic             listo_o
);

  logic [ANCHO-1:0] cnt_q;
  logic [ANCHO-1:0] cnt_d;

  assign listo_o = (cnt_q == objetivo_i);

  // Next count: clear has priority, then count up until the target is reached
  always_comb begin
    cnt_d = cnt_q;
    if (carga_i) begin
      cnt_d = '0;
    end else if (cuenta_i && !listo_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/compuertas_secuenciador.sv
// Sweeps gate selects, drives all 8 input combinations per gate and builds its truth table.
// Latency: 1 + 8*(SETTLE+1) cycles from ACTIVAR to tabla_valida_o for each gate.
// Backpressure: table held in ENTREGA with gate inputs frozen until tabla_lista_i.
module compuertas_secuenciador
  import compuertas_pkg::*;
#(
  parameter int SETTLE    = 2,
  parameter int ANCHO_SEL = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inicio_i,
  input  logic                 cancelar_i,
  input  logic [ANCHO_SEL-1:0] sel_ini_i,
  input  logic [ANCHO_SEL-1:0] sel_fin_i,
  output logic                 ocupado_o,
  output logic                 fin_o,
  output logic                 error_o,
  output logic                 act_o,
  output logic [ANCHO_SEL-1:0] sel_o,
  output logic                 ent1_o,
  output logic                 ent2_o,
  output logic                 ent3_o,
  input  logic                 sal_i,
  output logic [7:0]           tabla_o,
  output logic [ANCHO_SEL-1:0] tabla_sel_o,
  output logic                 tabla_valida_o,
  input  logic                 tabla_lista_i
);

  // APLICAR lasts SETTLE cycles; the counter flags on its last one.
  // With SETTLE=0 APLICAR is skipped, so the target value is irrelevant.
  localparam logic [ANCHO_ESPERA-1:0] OBJETIVO =
    (SETTLE == 0) ? '0 : ANCHO_ESPERA'(SETTLE - 1);
  localparam logic [ANCHO_COMB-1:0] ULTIMA_COMB = ANCHO_COMB'(NUM_COMB - 1);

  estado_t                 estado_q, estado_d;
  logic [ANCHO_SEL-1:0]    sel_q, sel_d;
  logic [ANCHO_SEL-1:0]    sel_fin_q, sel_fin_d;
  logic [ANCHO_COMB-1:0]   comb_q, comb_d;
  logic [NUM_COMB-1:0]     tabla_int_q, tabla_int_d;
  logic [7:0]              tabla_q, tabla_d;
  logic [ANCHO_SEL-1:0]    tabla_sel_q, tabla_sel_d;
  logic                    fin_err_q, fin_err_d;

  logic                    espera_carga;
  logic                    espera_cuenta;
  logic                    espera_listo;
  logic                    rango_ok;
  logic                    ultimo_sel;
  estado_t                 tras_comb;

  assign espera_carga  = (estado_q == ACTIVAR) || (estado_q == MUESTREO);
  assign espera_cuenta = (estado_q == APLICAR);

  compuertas_espera #(
    .ANCHO (ANCHO_ESPERA)
  ) u_espera (
    .clk        (clk),
    .rst_n      (rst_n),
    .carga_i    (espera_carga),
    .cuenta_i   (espera_cuenta),
    .objetivo_i (OBJETIVO),
    .listo_o    (espera_listo)
  );

  // Compare with one extra bit so sel_fin = all-ones ends the sweep without wrapping
  assign rango_ok   = ({1'b0, sel_ini_i} <= {1'b0, sel_fin_i});
  assign ultimo_sel = ({1'b0, sel_q} >= {1'b0, sel_fin_q});
  assign tras_comb  = (SETTLE == 0) ? MUESTREO : APLICAR;

  // Outputs decoded from registered state only
  assign ocupado_o      = (estado_q != REPOSO);
  assign act_o          = (estado_q == ACTIVAR) || (estado_q == APLICAR) ||
                          (estado_q == MUESTREO) || (estado_q == ENTREGA);
  assign fin_o          = (estado_q == FIN) || fin_err_q;
  assign error_o        = fin_err_q;
  assign sel_o          = sel_q;
  assign ent1_o         = comb_q[2];
  assign ent2_o         = comb_q[1];
  assign ent3_o         = comb_q[0];
  assign tabla_o        = tabla_q;
  assign tabla_sel_o    = tabla_sel_q;
  assign tabla_valida_o = (estado_q == ENTREGA);

  // Next-state and datapath updates; abort overrides everything outside REPOSO
  always_comb begin
    estado_d    = estado_q;
    sel_d       = sel_q;
    sel_fin_d   = sel_fin_q;
    comb_d      = comb_q;
    tabla_int_d = tabla_int_q;
    tabla_d     = tabla_q;
    tabla_sel_d = tabla_sel_q;
    fin_err_d   = 1'b0;

    case (estado_q)
      REPOSO: begin
        if (inicio_i) begin
          if (rango_ok) begin
            sel_d     = sel_ini_i;
            sel_fin_d = sel_fin_i;
            estado_d  = ACTIVAR;
          end else begin
            fin_err_d = 1'b1;
          end
        end
      end
      ACTIVAR: begin
        comb_d      = '0;
        tabla_int_d = '0;
        estado_d    = tras_comb;
      end
      APLICAR: begin
        if (espera_listo) begin
          estado_d = MUESTREO;
        end
      end
      MUESTREO: begin
        tabla_int_d[comb_q] = sal_i;
        // Wraps 7 -> 0 so the inputs return to 000 once the table is complete
        comb_d = comb_q + 1'b1;
        if (comb_q == ULTIMA_COMB) begin
          tabla_d     = tabla_int_d;
          tabla_sel_d = sel_q;
          estado_d    = ENTREGA;
        end else begin
          estado_d = tras_comb;
        end
      end
      ENTREGA: begin
        if (tabla_lista_i) begin
          if (ultimo_sel) begin
            estado_d = FIN;
          end else begin
            sel_d    = sel_q + 1'b1;
            estado_d = ACTIVAR;
          end
        end
      end
      FIN: begin
        estado_d = REPOSO;
      end
      default: begin
        estado_d = REPOSO;
      end
    endcase

    if (cancelar_i && (estado_q != REPOSO)) begin
      estado_d    = REPOSO;
      comb_d      = '0;
      tabla_d     = tabla_q;
      tabla_sel_d = tabla_sel_q;
      sel_d       = sel_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q    <= REPOSO;
      sel_q       <= '0;
      sel_fin_q   <= '0;
      comb_q      <= '0;
      tabla_int_q <= '0;
      tabla_q     <= '0;
      tabla_sel_q <= '0;
      fin_err_q   <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      sel_q       <= sel_d;
      sel_fin_q   <= sel_fin_d;
      comb_q      <= comb_d;
      tabla_int_q <= tabla_int_d;
      tabla_q     <= tabla_d;
      tabla_sel_q <= tabla_sel_d;
      fin_err_q   <= fin_err_d;
    end
  end

endmodule

// File: tb/tb_compuertas_secuenciador.sv
// Bench for the gate sequencer: gate model, scoreboard of expected tables, directed scenarios.
// Latency: two builds checked, SETTLE=2 (25 cycles) and SETTLE=0 (9 cycles).
// Backpressure: tabla_lista held low in one scenario to freeze the handshake.
module tb_compuertas_secuenciador;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  // Instance A (SETTLE=2)
  logic       inicio, cancelar, sal, tabla_lista;
  logic [2:0] sel_ini, sel_fin;
  logic       ocupado, fin, error, act, ent1, ent2, ent3, tabla_valida;
  logic [2:0] sel, tabla_sel;
  logic [7:0] tabla;
  // Instance B (SETTLE=0)
  logic       b_inicio, b_cancelar, b_sal, b_tabla_lista;
  logic [2:0] b_sel_ini, b_sel_fin;
  logic       b_ocupado, b_fin, b_error, b_act, b_ent1, b_ent2, b_ent3, b_tabla_valida;
  logic [2:0] b_sel, b_tabla_sel;
  logic [7:0] b_tabla;

  int passed = 0;
  int total  = 0;
  int fin_cnt = 0;
  int err_cnt = 0;
  logic [10:0] q_a[$];
  logic [10:0] q_b[$];

  compuertas_secuenciador #(.SETTLE(2), .ANCHO_SEL(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .inicio_i(inicio), .cancelar_i(cancelar),
    .sel_ini_i(sel_ini), .sel_fin_i(sel_fin), .ocupado_o(ocupado), .fin_o(fin),
    .error_o(error), .act_o(act), .sel_o(sel), .ent1_o(ent1), .ent2_o(ent2),
    .ent3_o(ent3), .sal_i(sal), .tabla_o(tabla), .tabla_sel_o(tabla_sel),
    .tabla_valida_o(tabla_valida), .tabla_lista_i(tabla_lista)
  );

  compuertas_secuenciador #(.SETTLE(0), .ANCHO_SEL(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .inicio_i(b_inicio), .cancelar_i(b_cancelar),
    .sel_ini_i(b_sel_ini), .sel_fin_i(b_sel_fin), .ocupado_o(b_ocupado), .fin_o(b_fin),
    .error_o(b_error), .act_o(b_act), .sel_o(b_sel), .ent1_o(b_ent1), .ent2_o(b_ent2),
    .ent3_o(b_ent3), .sal_i(b_sal), .tabla_o(b_tabla), .tabla_sel_o(b_tabla_sel),
    .tabla_valida_o(b_tabla_valida), .tabla_lista_i(b_tabla_lista)
  );

  // External gate unit: 001=AND3, 010=OR3, 011=XOR3, otherwise 0; 0 when disabled
  function automatic logic puerta(input logic a, input logic [2:0] s, input logic [2:0] e);
    if (!a) return 1'b0;
    case (s)
      3'd1:    return &e;
      3'd2:    return |e;
      3'd3:    return ^e;
      default: return 1'b0;
    endcase
  endfunction

  assign sal   = puerta(act, sel, {ent1, ent2, ent3});
  assign b_sal = puerta(b_act, b_sel, {b_ent1, b_ent2, b_ent3});

  task automatic chk(input string nombre, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nombre, got, exp);
  endtask

  // Monitor: pops the scoreboard on every accepted table, counts fin/error pulses
  always @(negedge clk) begin
    logic [10:0] e;
    if (rst_n) begin
      if (fin)   fin_cnt++;
      if (error) err_cnt++;
      if (tabla_valida && tabla_lista) begin
        if (q_a.size() == 0) begin
          total++;
          $display("FAIL tabla_a_inesperada: got sel=%0d tabla=0x%0h expected none", tabla_sel, tabla);
        end else begin
          e = q_a.pop_front();
          chk("tabla_a", {21'd0, tabla_sel, tabla}, {21'd0, e});
        end
      end
      if (b_tabla_valida && b_tabla_lista) begin
        if (q_b.size() == 0) begin
          total++;
          $display("FAIL tabla_b_inesperada: got sel=%0d tabla=0x%0h expected none", b_tabla_sel, b_tabla);
        end else begin
          e = q_b.pop_front();
          chk("tabla_b", {21'd0, b_tabla_sel, b_tabla}, {21'd0, e});
        end
      end
    end
  end

  task automatic paso();
    @(posedge clk);
    #2;
  endtask

  task automatic arrancar(input logic [2:0] a, input logic [2:0] b);
    sel_ini = a;
    sel_fin = b;
    inicio  = 1'b1;
    paso();
    inicio  = 1'b0;
  endtask

  // Cycles from ACTIVAR (current cycle) until tabla_valida
  task automatic medir_a(output int n);
    n = 0;
    while (!tabla_valida && n < 300) begin
      paso();
      n++;
    end
  endtask

  task automatic esperar_fin(input string nombre);
    int k;
    k = 0;
    while (!fin && k < 600) begin
      paso();
      k++;
    end
    total++;
    if (fin) passed++;
    else $display("FAIL %s: got no fin expected fin within 600 cycles", nombre);
  endtask

  function automatic logic [21:0] salidas_a();
    return {ocupado, fin, error, act, sel, ent1, ent2, ent3, tabla, tabla_sel, tabla_valida};
  endfunction

  initial begin
    int n, k, f0, e0;
    logic estable, envuelto;
    logic [21:0] foto;

    rst_n = 1'b1;
    inicio = 0; cancelar = 0; sel_ini = 0; sel_fin = 0; tabla_lista = 1;
    b_inicio = 0; b_cancelar = 0; b_sel_ini = 0; b_sel_fin = 0; b_tabla_lista = 1;
    #1 rst_n = 1'b0;
    repeat (3) paso();
    chk("reset_a", {10'd0, salidas_a()}, 32'd0);
    chk("reset_b", {10'd0, b_ocupado, b_fin, b_error, b_act, b_sel, b_ent1, b_ent2, b_ent3,
                    b_tabla, b_tabla_sel, b_tabla_valida}, 32'd0);
    rst_n = 1'b1;
    repeat (2) paso();

    // Sweep 1..3 with consumer always ready
    f0 = fin_cnt; e0 = err_cnt;
    q_a.push_back({3'd1, 8'h80});
    q_a.push_back({3'd2, 8'hFE});
    q_a.push_back({3'd3, 8'h96});
    arrancar(3'd1, 3'd3);
    chk("act_en_activar", {31'd0, act}, 32'd1);
    medir_a(n);
    chk("latencia_s2", n, 25);
    esperar_fin("fin_barrido");
    paso(); paso();
    chk("fin_una_vez", fin_cnt - f0, 1);
    chk("error_nunca", err_cnt - e0, 0);
    chk("cola_vacia_barrido", q_a.size(), 0);

    // Backpressure: consumer stalls for 10 cycles in ENTREGA
    tabla_lista = 1'b0;
    q_a.push_back({3'd1, 8'h80});
    q_a.push_back({3'd2, 8'hFE});
    arrancar(3'd1, 3'd2);
    medir_a(n);
    chk("latencia_bp", n, 25);
    foto = salidas_a();
    estable = 1'b1;
    repeat (10) begin
      paso();
      if (salidas_a() !== foto) estable = 1'b0;
    end
    chk("estable_bp", {31'd0, estable}, 32'd1);
    chk("sin_entrega_bp", q_a.size(), 2);
    tabla_lista = 1'b1;
    esperar_fin("fin_bp");
    paso();
    chk("cola_vacia_bp", q_a.size(), 0);

    // Bad range: immediate fin+error, never busy
    arrancar(3'd5, 3'd2);
    chk("malo_pulso", {28'd0, fin, error, ocupado, act}, 32'hC);
    paso();
    chk("malo_despues", {28'd0, fin, error, ocupado, act}, 32'h0);

    // Upper edge: 7..7, sel must never wrap to 0
    f0 = fin_cnt;
    q_a.push_back({3'd7, 8'h00});
    arrancar(3'd7, 3'd7);
    envuelto = 1'b0;
    k = 0;
    while (!fin && k < 600) begin
      if (sel !== 3'd7) envuelto = 1'b1;
      paso();
      k++;
    end
    chk("fin_sel7", {31'd0, fin}, 32'd1);
    chk("sel7_sin_envolver", {31'd0, envuelto}, 32'd0);
    paso();
    chk("cola_vacia_sel7", q_a.size(), 0);
    chk("fin_sel7_una_vez", fin_cnt - f0, 1);

    // Abort during MUESTREO of sel 2, comb 4
    f0 = fin_cnt;
    q_a.push_back({3'd1, 8'h80});
    arrancar(3'd1, 3'd3);
    k = 0;
    while (!(sel == 3'd2 && {ent1, ent2, ent3} == 3'd4) && k < 600) begin
      paso();
      k++;
    end
    chk("llega_sel2_comb4", {28'd0, sel, ent1}, {28'd0, 3'd2, 1'b1});
    paso();                 // second APLICAR cycle
    paso();                 // MUESTREO
    cancelar = 1'b1;
    paso();
    cancelar = 1'b0;
    chk("cancelado", {28'd0, act, ocupado, tabla_valida, fin}, 32'd0);
    repeat (5) paso();
    chk("cancel_sin_fin", fin_cnt - f0, 0);
    chk("cola_vacia_cancel", q_a.size(), 0);

    // Async reset mid-APLICAR, then a clean run
    arrancar(3'd1, 3'd3);
    k = 0;
    while (!({ent1, ent2, ent3} == 3'd2 && act) && k < 600) begin
      paso();
      k++;
    end
    #1 rst_n = 1'b0;
    #1 chk("reset_asinc", {10'd0, salidas_a()}, 32'd0);
    paso();
    rst_n = 1'b1;
    paso();
    f0 = fin_cnt;
    q_a.push_back({3'd3, 8'h96});
    arrancar(3'd3, 3'd3);
    medir_a(n);
    chk("latencia_post_reset", n, 25);
    esperar_fin("fin_post_reset");
    paso();
    chk("cola_vacia_post_reset", q_a.size(), 0);
    chk("fin_post_reset_una_vez", fin_cnt - f0, 1);

    // SETTLE=0 build: 2..2 delivered 9 cycles after ACTIVAR
    q_b.push_back({3'd2, 8'hFE});
    b_sel_ini = 3'd2;
    b_sel_fin = 3'd2;
    b_inicio  = 1'b1;
    paso();
    b_inicio  = 1'b0;
    n = 0;
    while (!b_tabla_valida && n < 300) begin
      paso();
      n++;
    end
    chk("latencia_s0", n, 9);
    k = 0;
    while (!b_fin && k < 100) begin
      paso();
      k++;
    end
    chk("fin_s0", {31'd0, b_fin}, 32'd1);
    paso();
    chk("cola_vacia_s0", q_b.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
